// File: rtl/bin_segment_serializer_if.sv
// Handshake and LED-chain bundle for bin_segment_serializer.
// The master side is the host/consumer; the slave side is the serializer.
interface bin_segment_serializer_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int MAX_DIGITS        = 5,
  parameter int DIGIT_COUNT_WIDTH = $clog2(MAX_DIGITS + 1)
);
  logic                         start;
  logic [DATA_WIDTH-1:0]        data;
  logic [DIGIT_COUNT_WIDTH-1:0] digit_count;
  logic                         hex_mode;
  logic                         blank_lz;
  logic                         next_led;
  logic                         led_data;
  logic                         led_valid;
  logic                         busy;
  logic                         done;
  logic                         overflow;

  modport master (
    output start, data, digit_count, hex_mode, blank_lz, next_led,
    input  led_data, led_valid, busy, done, overflow
  );

  modport slave (
    input  start, data, digit_count, hex_mode, blank_lz, next_led,
    output led_data, led_valid, busy, done, overflow
  );
endinterface

// File: rtl/bin_segment_serializer.sv
// Binary-to-digit converter feeding a 7-segment LED shift chain.
// A captured value becomes decimal digits (iterative double-dabble, one input
// bit per cycle) or hex digits (single cycle). The selected digits are then
// streamed most significant first, segment a..g, one bit per next_led strobe.
// The BCD register doubles as the digit store in both modes.
module bin_segment_serializer #(
  parameter int DATA_WIDTH        = 16,
  parameter int MAX_DIGITS        = 5,
  parameter int DIGIT_COUNT_WIDTH = $clog2(MAX_DIGITS + 1)
) (
  input logic                     clk,
  input logic                     rst_n,
  bin_segment_serializer_if.slave bus
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int EXT_W = (DATA_WIDTH > BCD_W) ? DATA_WIDTH : BCD_W;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int DIG_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_SHIFT   = 2'd2;

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // True when any digit at or above index n is nonzero (value truncated by n).
  function automatic logic high_digits_nz(input logic [BCD_W-1:0] v,
                                          input logic [DIGIT_COUNT_WIDTH-1:0] n);
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i >= int'(n) && v[4*i +: 4] != 4'd0) nz = 1'b1;
    end
    return nz;
  endfunction

  // Saturate the requested digit count into [1, MAX_DIGITS].
  function automatic logic [DIGIT_COUNT_WIDTH-1:0] clamp_count(
      input logic [DIGIT_COUNT_WIDTH-1:0] dc);
    if (dc == '0) return DIGIT_COUNT_WIDTH'(1);
    if (dc > DIGIT_COUNT_WIDTH'(MAX_DIGITS)) return DIGIT_COUNT_WIDTH'(MAX_DIGITS);
    return dc;
  endfunction

  // Segment map, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  logic [1:0]                   state;
  logic [DATA_WIDTH-1:0]        value_r;
  logic [BCD_W-1:0]             bcd_r;
  logic [DIGIT_COUNT_WIDTH-1:0] n_r;
  logic                         hex_r;
  logic                         blank_r;
  logic                         ovf_r;
  logic                         done_r;
  logic [CNT_W-1:0]             bit_cnt;
  logic [DIG_W-1:0]             dig_idx;
  logic [2:0]                   seg_idx;

  logic [EXT_W-1:0]             data_ext;
  logic [BCD_W-1:0]             hex_digits;
  logic                         hex_hi_nz;
  logic [BCD_W-1:0]             bcd_adj;
  logic [BCD_W-1:0]             bcd_next;
  logic                         bcd_carry;
  logic                         last_bit;

  logic [3:0]                   cur_digit;
  logic                         upper_nz;
  logic                         cur_blank;
  logic [6:0]                   cur_pattern;

  // Next-step values for both conversion modes, computed from the captured value.
  always_comb begin
    data_ext   = EXT_W'(value_r);
    hex_digits = data_ext[BCD_W-1:0];
    hex_hi_nz  = |(data_ext >> BCD_W);
    bcd_adj    = add3_all(bcd_r);
    {bcd_carry, bcd_next} = {bcd_adj, value_r[DATA_WIDTH-1]};
    last_bit   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  end

  // Pattern of the digit being shifted, with leading-zero blanking applied.
  always_comb begin
    cur_digit = bcd_r[4*int'(dig_idx) +: 4];
    upper_nz  = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i >= int'(dig_idx) && i < int'(n_r) && bcd_r[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
    cur_blank   = blank_r && (dig_idx != '0) && !upper_nz;
    cur_pattern = cur_blank ? 7'h00 : seg_pattern(cur_digit);
  end

  // Control and datapath sequencing: capture, convert, then stream bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      value_r <= '0;
      bcd_r   <= '0;
      n_r     <= '0;
      hex_r   <= 1'b0;
      blank_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      bit_cnt <= '0;
      dig_idx <= '0;
      seg_idx <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            value_r <= bus.data;
            hex_r   <= bus.hex_mode;
            blank_r <= bus.blank_lz;
            n_r     <= clamp_count(bus.digit_count);
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            bit_cnt <= '0;
            dig_idx <= '0;
            seg_idx <= '0;
            state   <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          if (hex_r) begin
            bcd_r   <= hex_digits;
            ovf_r   <= hex_hi_nz | high_digits_nz(hex_digits, n_r);
            dig_idx <= DIG_W'(n_r - DIGIT_COUNT_WIDTH'(1));
            state   <= S_SHIFT;
          end else begin
            value_r <= value_r << 1;
            bcd_r   <= bcd_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            ovf_r   <= ovf_r | bcd_carry | (last_bit && high_digits_nz(bcd_next, n_r));
            if (last_bit) begin
              dig_idx <= DIG_W'(n_r - DIGIT_COUNT_WIDTH'(1));
              state   <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (bus.next_led) begin
            if (seg_idx == 3'd6) begin
              seg_idx <= 3'd0;
              if (dig_idx == '0) begin
                done_r <= 1'b1;
                state  <= S_IDLE;
              end else begin
                dig_idx <= dig_idx - DIG_W'(1);
              end
            end else begin
              seg_idx <= seg_idx + 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.led_valid = (state == S_SHIFT);
  assign bus.busy      = (state != S_IDLE);
  assign bus.led_data  = (state == S_SHIFT) & cur_pattern[seg_idx];
  assign bus.done      = done_r;
  assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_bin_segment_serializer.sv
// Directed bench for bin_segment_serializer: decimal/hex conversion,
// blanking, overflow, digit-count clamping, protocol corner cases and reset.
`timescale 1ns/1ps
module tb_bin_segment_serializer;
  localparam int DATA_WIDTH = 16;
  localparam int MAX_DIGITS = 5;
  localparam int DCW        = $clog2(MAX_DIGITS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [6:0] got_pat [0:7];

  bin_segment_serializer_if #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIGITS(MAX_DIGITS)) bus ();

  bin_segment_serializer #(.DATA_WIDTH(DATA_WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic start_conv(input logic [15:0] d, input logic [DCW-1:0] dc,
                            input logic hx, input logic blz, input logic nl);
    bus.data        = d;
    bus.digit_count = dc;
    bus.hex_mode    = hx;
    bus.blank_lz    = blz;
    bus.next_led    = nl;
    bus.start       = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.next_led = 1'b0;
  endtask

  // Counts cycles from the start edge until led_valid; optionally holds next_led during CONVERT.
  task automatic wait_valid(input string tag, input int exp_lat, input logic pulse);
    int lat;
    lat = 0;
    check({tag, "_busy"}, bus.busy, 1);
    while (bus.led_valid !== 1'b1 && lat < 40) begin
      bus.next_led = pulse;
      tick();
      bus.next_led = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  // Consumes nd*7 bits with next_led high, then checks the done pulse.
  task automatic collect(input string tag, input int nd, input logic inject);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < nd; k++) begin
      for (int s = 0; s < 7; s++) begin
        if (bus.led_valid !== 1'b1) ok = 1'b0;
        got_pat[k][s] = bus.led_data;
        if (inject && k == 0 && s == 3) begin
          bus.start       = 1'b1;
          bus.data        = 16'd777;
          bus.digit_count = 3'd1;
          bus.hex_mode    = 1'b1;
        end
        bus.next_led = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.next_led = 1'b0;
      end
    end
    check({tag, "_valid_all"}, ok, 1);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_valid_end"}, bus.led_valid, 0);
    check({tag, "_busy_end"}, bus.busy, 0);
    tick();
    check({tag, "_done_1cyc"}, bus.done, 0);
  endtask

  task automatic check_pats(input string tag, input int nd,
                            input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                            input logic [6:0] e3, input logic [6:0] e4);
    logic [6:0] e [0:4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int k = 0; k < nd; k++) begin
      check($sformatf("%s_pat%0d", tag, k), got_pat[k], e[k]);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.data        = '0;
    bus.digit_count = '0;
    bus.hex_mode    = 1'b0;
    bus.blank_lz    = 1'b0;
    bus.next_led    = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.led_valid, 0);
    check("rst_data", bus.led_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.overflow, 0);
    rst_n = 1'b1;
    tick();

    // Decimal 1234, five digits, no blanking
    start_conv(16'd1234, 3'd5, 1'b0, 1'b0, 1'b0);
    wait_valid("dec1234", 16, 1'b0);
    check("dec1234_ovf", bus.overflow, 0);
    collect("dec1234", 5, 1'b0);
    check_pats("dec1234", 5, 7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66);

    // Leading-zero blanking
    start_conv(16'd1234, 3'd5, 1'b0, 1'b1, 1'b0);
    wait_valid("blank1234", 16, 1'b0);
    collect("blank1234", 5, 1'b0);
    check_pats("blank1234", 5, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66);

    // Zero value with blanking keeps digit 0
    start_conv(16'd0, 3'd3, 1'b0, 1'b1, 1'b0);
    wait_valid("zero", 16, 1'b0);
    collect("zero", 3, 1'b0);
    check_pats("zero", 3, 7'h00, 7'h00, 7'h3F, 7'h00, 7'h00);

    // Hex 0xBEEF, four digits
    start_conv(16'hBEEF, 3'd4, 1'b1, 1'b0, 1'b0);
    wait_valid("hexbeef", 1, 1'b0);
    check("hexbeef_ovf", bus.overflow, 0);
    collect("hexbeef", 4, 1'b0);
    check_pats("hexbeef", 4, 7'h7C, 7'h79, 7'h79, 7'h71, 7'h00);

    // Decimal overflow: 65535 in four digits shows 5535
    start_conv(16'd65535, 3'd4, 1'b0, 1'b0, 1'b0);
    wait_valid("ovf65535", 16, 1'b0);
    check("ovf65535_ovf", bus.overflow, 1);
    collect("ovf65535", 4, 1'b0);
    check_pats("ovf65535", 4, 7'h6D, 7'h6D, 7'h4F, 7'h6D, 7'h00);
    check("ovf65535_held", bus.overflow, 1);

    // digit_count 0 clamps to one digit; overflow cleared by new start
    start_conv(16'd5, 3'd0, 1'b0, 1'b0, 1'b0);
    check("dc0_ovf_clear", bus.overflow, 0);
    wait_valid("dc0", 16, 1'b0);
    collect("dc0", 1, 1'b0);
    check_pats("dc0", 1, 7'h6D, 7'h00, 7'h00, 7'h00, 7'h00);

    // digit_count 7 clamps to five digits
    start_conv(16'd1234, 3'd7, 1'b0, 1'b0, 1'b0);
    wait_valid("dc7", 16, 1'b0);
    collect("dc7", 5, 1'b0);
    check_pats("dc7", 5, 7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66);

    // Hex overflow from a digit above n: 0x1F in one digit shows F
    start_conv(16'h001F, 3'd1, 1'b1, 1'b0, 1'b0);
    wait_valid("hexovf", 1, 1'b0);
    check("hexovf_ovf", bus.overflow, 1);
    collect("hexovf", 1, 1'b0);
    check_pats("hexovf", 1, 7'h71, 7'h00, 7'h00, 7'h00, 7'h00);

    // next_led held during CONVERT does not advance
    start_conv(16'd98, 3'd2, 1'b0, 1'b0, 1'b0);
    wait_valid("nlconv", 16, 1'b1);
    collect("nlconv", 2, 1'b0);
    check_pats("nlconv", 2, 7'h6F, 7'h7F, 7'h00, 7'h00, 7'h00);

    // start with new data during SHIFT is ignored
    start_conv(16'd305, 3'd3, 1'b0, 1'b0, 1'b0);
    wait_valid("startshift", 16, 1'b0);
    collect("startshift", 3, 1'b1);
    check_pats("startshift", 3, 7'h4F, 7'h3F, 7'h6D, 7'h00, 7'h00);

    // start and next_led together in IDLE: conversion proceeds normally
    start_conv(16'd42, 3'd2, 1'b0, 1'b0, 1'b1);
    wait_valid("startnl", 16, 1'b0);
    collect("startnl", 2, 1'b0);
    check_pats("startnl", 2, 7'h66, 7'h5B, 7'h00, 7'h00, 7'h00);

    // Reset at bit 10 of SHIFT (led_data is 1 there, overflow is 1)
    start_conv(16'd65535, 3'd4, 1'b0, 1'b0, 1'b0);
    wait_valid("rstmid", 16, 1'b0);
    for (int b = 0; b < 10; b++) begin
      bus.next_led = 1'b1;
      tick();
      bus.next_led = 1'b0;
    end
    check("rstmid_pre_data", bus.led_data, 1);
    check("rstmid_pre_ovf", bus.overflow, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_valid", bus.led_valid, 0);
    check("rstmid_data", bus.led_data, 0);
    check("rstmid_ovf", bus.overflow, 0);
    check("rstmid_done", bus.done, 0);
    start_conv(16'd7, 3'd1, 1'b0, 1'b0, 1'b0);
    wait_valid("after_rst", 16, 1'b0);
    collect("after_rst", 1, 1'b0);
    check_pats("after_rst", 1, 7'h07, 7'h00, 7'h00, 7'h00, 7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
